// File: rtl/core_types_pkg.sv
// Core-wide scalar types shared by the RISC-V core and its debug taps.
package core_types_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;
    typedef logic [31:0] data_t;
endpackage

// File: rtl/pkg_trace_buffer.sv
// Record layout and FSM encoding for the retire-trace recorder.
package pkg_trace_buffer;
    import core_types_pkg::*;

    typedef struct packed {
        addr_t       pc;
        instr_t      instr;
        logic [4:0]  rd;
        logic        reg_write;
        data_t       result;
        logic        mem_we;
        addr_t       mem_addr;
        data_t       mem_wdata;
        logic [31:0] cycle;
    } trace_entry_t;

    typedef enum logic [1:0] {IDLE, CAPTURE, POST, READOUT} trace_state_t;
endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH records, one synchronous write port, one asynchronous read port.
// No reset; contents are only meaningful where head/tail say so.
module trace_ram
    import pkg_trace_buffer::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  trace_entry_t  wdata,
    input  logic [AW-1:0] raddr,
    output trace_entry_t  rdata
);
    trace_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/trace_buffer.sv
// Retire-trace recorder: circular capture, PC-match trigger with post window, oldest-first drain (rd_entry combinational, one pop/cycle under rd_ready).
// Define TRACE_DISPLAY_EN to echo every captured record with $display; behaviour is otherwise identical.
module trace_buffer
    import core_types_pkg::*;
    import pkg_trace_buffer::*;
#(
    parameter int DEPTH      = 16,
    parameter int POST_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   trig_en,
    input  addr_t                  trig_pc,
    input  logic                   retire_valid,
    input  addr_t                  retire_pc,
    input  instr_t                 retire_instr,
    input  logic [4:0]             retire_rd,
    input  logic                   retire_reg_write,
    input  data_t                  retire_result,
    input  logic                   retire_mem_we,
    input  addr_t                  retire_mem_addr,
    input  data_t                  retire_mem_wdata,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output trace_entry_t           rd_entry,
    output trace_state_t           state,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   triggered
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head, tail;
    logic [CW-1:0] post_cnt, count_next;
    logic [31:0]   cycle_cnt;
    trace_state_t  state_d;
    trace_entry_t  wr_entry, head_entry;
    logic          full, capturing, wr_en, trig_hit, pop;

    assign full      = (count == CW'(DEPTH));
    assign capturing = (state == CAPTURE) || (state == POST);
    assign wr_en     = capturing && retire_valid && !arm;
    // stop outranks the trigger, so a coincident match is recorded but does not fire
    assign trig_hit  = (state == CAPTURE) && retire_valid && trig_en &&
                       (retire_pc == trig_pc) && !arm && !stop;
    assign rd_valid  = (state == READOUT) && (count != '0);
    assign pop       = rd_valid && rd_ready && !arm;
    assign rd_entry  = rd_valid ? head_entry : '0;

    assign wr_entry = '{pc: retire_pc, instr: retire_instr, rd: retire_rd,
                        reg_write: retire_reg_write, result: retire_result,
                        mem_we: retire_mem_we, mem_addr: retire_mem_addr,
                        mem_wdata: retire_mem_wdata, cycle: cycle_cnt};

    always_comb begin
        count_next = count;
        if (wr_en && !full) begin
            count_next = count + 1'b1;
        end else if (pop) begin
            count_next = count - 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        if (arm) begin
            state_d = CAPTURE;
        end else begin
            case (state)
                CAPTURE: begin
                    if (stop) begin
                        state_d = (count_next == '0) ? IDLE : READOUT;
                    end else if (trig_hit) begin
                        state_d = (POST_DEPTH == 0) ? READOUT : POST;
                    end
                end
                POST: begin
                    if (stop || (wr_en && post_cnt == CW'(1))) begin
                        state_d = (count_next == '0) ? IDLE : READOUT;
                    end
                end
                READOUT: begin
                    if (pop && count_next == '0) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
            post_cnt  <= CW'(POST_DEPTH);
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            state     <= state_d;
            if (arm) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                triggered <= 1'b0;
                post_cnt  <= CW'(POST_DEPTH);
            end else begin
                count <= count_next;
                if (wr_en) begin
                    tail <= tail + 1'b1;
                    if (full) begin
                        head     <= head + 1'b1;
                        overflow <= 1'b1;
                    end
                    if (state == POST) begin
                        post_cnt <= post_cnt - 1'b1;
                    end
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (trig_hit) begin
                    triggered <= 1'b1;
                end
            end
        end
    end

    trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (head_entry)
    );

`ifdef TRACE_DISPLAY_EN
    always @(posedge clk) begin
        if (!reset && wr_en) begin
            if (retire_reg_write && retire_mem_we)
                $display("[%08h] pc=%08h instr=%08h x%0d=%08h mem[%08h]=%08h", cycle_cnt, retire_pc,
                         retire_instr, retire_rd, retire_result, retire_mem_addr, retire_mem_wdata);
            else if (retire_reg_write)
                $display("[%08h] pc=%08h instr=%08h x%0d=%08h", cycle_cnt, retire_pc,
                         retire_instr, retire_rd, retire_result);
            else if (retire_mem_we)
                $display("[%08h] pc=%08h instr=%08h mem[%08h]=%08h", cycle_cnt, retire_pc,
                         retire_instr, retire_mem_addr, retire_mem_wdata);
            else
                $display("[%08h] pc=%08h instr=%08h", cycle_cnt, retire_pc, retire_instr);
        end
    end
`endif
endmodule

// File: tb/tb_trace_buffer.sv
// Cycle table drives trace_buffer (DEPTH=8, POST_DEPTH=2); a record scoreboard checks every drained entry.
module tb_trace_buffer;
    import core_types_pkg::*;
    import pkg_trace_buffer::*;

    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         arm = 1'b0, stop = 1'b0, trig_en = 1'b0;
    addr_t        trig_pc = '0;
    logic         retire_valid = 1'b0;
    addr_t        retire_pc = '0;
    instr_t       retire_instr = '0;
    logic [4:0]   retire_rd = '0;
    logic         retire_reg_write = 1'b0;
    data_t        retire_result = '0;
    logic         retire_mem_we = 1'b0;
    addr_t        retire_mem_addr = '0;
    data_t        retire_mem_wdata = '0;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    trace_entry_t rd_entry;
    trace_state_t state;
    logic [3:0]   count;
    logic         overflow, triggered;

    trace_buffer #(.DEPTH(DEPTH), .POST_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .retire_rd(retire_rd), .retire_reg_write(retire_reg_write), .retire_result(retire_result),
        .retire_mem_we(retire_mem_we), .retire_mem_addr(retire_mem_addr),
        .retire_mem_wdata(retire_mem_wdata), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_entry(rd_entry), .state(state), .count(count), .overflow(overflow), .triggered(triggered)
    );

    always #5 clk = ~clk;

    logic [31:0] tb_cyc;
    always @(posedge clk) begin
        if (reset) tb_cyc <= '0;
        else       tb_cyc <= tb_cyc + 1;
    end

    typedef struct {
        logic         rst, arm, stop, rv, ten;
        logic [31:0]  tpc, pc;
        logic         cap;
        trace_state_t st;
        int           cnt;
        logic         ovf, trg;
        int           drn;
    } vec_t;

    vec_t         vecs[$];
    trace_entry_t sb[$];
    int           checks = 0;
    int           errors = 0;

    function automatic vec_t mk(input logic rst, arm_i, stop_i, rv, ten, input logic [31:0] tpc, pc,
                                input logic cap, input trace_state_t st, input int cnt,
                                input logic ovf, trg, input int drn);
        vec_t v;
        v.rst = rst; v.arm = arm_i; v.stop = stop_i; v.rv = rv; v.ten = ten;
        v.tpc = tpc; v.pc = pc; v.cap = cap; v.st = st; v.cnt = cnt;
        v.ovf = ovf; v.trg = trg; v.drn = drn;
        return v;
    endfunction

    function automatic trace_entry_t mk_entry(input logic [31:0] pc, input logic [31:0] cyc);
        trace_entry_t e;
        e.pc        = pc;
        e.instr     = {pc[15:0], 16'h0513};
        e.rd        = pc[6:2];
        e.reg_write = pc[2];
        e.result    = ~pc;
        e.mem_we    = pc[3];
        e.mem_addr  = pc + 32'h1000;
        e.mem_wdata = pc ^ 32'hDEAD_BEEF;
        e.cycle     = cyc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_entry(input string name, input trace_entry_t act, input trace_entry_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 1: rd_ready held high; mode 2: rd_ready toggles 1,0,1,0...
    task automatic drain(input int mode);
        int           k;
        logic         rdy, stalled;
        trace_entry_t held;
        k = 0;
        stalled = 1'b0;
        held = '0;
        while ((sb.size() > 0 || rd_valid) && k < 40) begin
            rdy = (mode == 1) ? 1'b1 : (k % 2 == 0);
            if (stalled) chk_entry("stall_stable", rd_entry, held);
            stalled = 1'b0;
            rd_ready = rdy;
            if (rd_valid && rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_record actual=%h required=none", rd_entry);
                end else begin
                    chk_entry("drain_entry", rd_entry, sb.pop_front());
                end
            end else if (rd_valid) begin
                stalled = 1'b1;
                held = rd_entry;
            end
            tick();
            k++;
        end
        rd_ready = 1'b0;
        chk("drain_in_budget", 64'(k < 40), 64'(1));
        chk("drain_end_state", 64'(state), 64'(IDLE));
        chk("drain_end_count", 64'(count), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t         v;
        trace_entry_t e;
        logic         exp_rv;

        // in-order drain of three records
        vecs.push_back(mk(1,0,0,0,0, 0, 0, 0, IDLE,    0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,0, 0, 0, 0, CAPTURE, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0,1,0, 0, 32'(4*i), 1, CAPTURE, i+1, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0, 0, READOUT, 3, 0, 0, 1));
        // wrap-around: 11 writes into 8 entries, drained with a stalling consumer
        vecs.push_back(mk(0,1,0,0,0, 0, 0, 0, CAPTURE, 0, 0, 0, 0));
        for (int i = 0; i < 11; i++)
            vecs.push_back(mk(0,0,0,1,0, 0, 32'(4*i), 1, CAPTURE, (i < 8) ? i+1 : 8, i >= 8, 0, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0, 0, READOUT, 8, 1, 0, 2));
        // trigger at 0x10, two post records, later retires ignored
        vecs.push_back(mk(0,1,0,0,1, 32'h10, 0, 0, CAPTURE, 0, 0, 0, 0));
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(0,0,0,1,1, 32'h10, 32'(4*i), i <= 6,
                              (i < 4) ? CAPTURE : (i < 6) ? POST : READOUT,
                              (i <= 6) ? i+1 : 7, 0, i >= 4, (i == 8) ? 1 : 0));
        // coincident events and empty stops
        vecs.push_back(mk(0,1,1,0,0, 0, 0, 0, CAPTURE, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, 32'h44, 32'h40, 1, CAPTURE, 1, 0, 0, 0));
        vecs.push_back(mk(0,0,1,1,1, 32'h44, 32'h44, 1, READOUT, 2, 0, 1'bx, 1));
        vecs.push_back(mk(0,1,0,0,0, 0, 0, 0, CAPTURE, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0, 0, IDLE,    0, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0, 0, IDLE,    0, 0, 0, 0));
        // reset in the middle of a five-record readout, then recapture
        vecs.push_back(mk(0,1,0,0,0, 0, 0, 0, CAPTURE, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0,1,0, 0, 32'h80 + 32'(4*i), 1, CAPTURE, i+1, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0, 0, READOUT, 5, 0, 0, 0));
        vecs.push_back(mk(1,0,0,0,0, 0, 0, 0, IDLE,    0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,0, 0, 0, 0, CAPTURE, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0, 0, 32'hA0, 1, CAPTURE, 1, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0, 0, READOUT, 1, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            e = mk_entry(v.pc, tb_cyc);
            reset = v.rst; arm = v.arm; stop = v.stop; trig_en = v.ten; trig_pc = v.tpc;
            retire_valid = v.rv; retire_pc = e.pc; retire_instr = e.instr; retire_rd = e.rd;
            retire_reg_write = e.reg_write; retire_result = e.result; retire_mem_we = e.mem_we;
            retire_mem_addr = e.mem_addr; retire_mem_wdata = e.mem_wdata;
            if (v.rst || v.arm) sb.delete();
            if (v.cap) begin
                if (sb.size() == DEPTH) void'(sb.pop_front());
                sb.push_back(e);
            end
            tick();
            reset = 1'b0; arm = 1'b0; stop = 1'b0; retire_valid = 1'b0;

            exp_rv = (v.st == READOUT) && (v.cnt != 0);
            chk($sformatf("v%0d_state", i), 64'(state), 64'(v.st));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(v.cnt));
            chk($sformatf("v%0d_overflow", i), 64'(overflow), 64'(v.ovf));
            if (v.trg !== 1'bx) chk($sformatf("v%0d_triggered", i), 64'(triggered), 64'(v.trg));
            chk($sformatf("v%0d_rd_valid", i), 64'(rd_valid), 64'(exp_rv));
            if (!exp_rv) chk_entry($sformatf("v%0d_rd_entry_zero", i), rd_entry, '0);
            if (v.drn != 0) drain(v.drn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
